minimac2_tx: RTL

- Transmit framer in the phy_tx_clk domain, downstream of the TX buffer RAM in the minimac2 memory block.
- Reads frame bytes from the TX buffer read port (txb_adr/txb_dat) and emits an MII nibble stream on phy_tx_en/phy_tx_data.
- Generates the preamble and SFD, optionally appends the Ethernet FCS, and enforces the inter-frame gap.
- Start/done handshake to the sys_clk control side uses signals already synchronised into phy_tx_clk by the caller.

---
 rtl/minimac2_pkg.sv | 29 ++
 rtl/minimac2_crc32_nibble.sv | 29 ++
 rtl/minimac2_tx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/minimac2_pkg.sv
// -----------------------------------------------------------------------------
// minimac2_pkg
// Shared definitions for the minimac2 MII framers: TX state encoding and the
// Ethernet framing / CRC-32 constants used by both the TX framer and the RX
// checker.
// -----------------------------------------------------------------------------
package minimac2_pkg;

    // Framer states. Each state names what the registered outputs are
    // currently showing, not what is being computed for the next cycle.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_FCS,
        ST_IFG
    } tx_state_e;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
    localparam logic [31:0] CRC_POLY        = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT        = 32'hFFFFFFFF;

    // Preamble plus SFD, in nibbles.
    localparam int PREAMBLE_LEN = 16;
    // FCS length, in nibbles.
    localparam int FCS_NIBBLES  = 8;

endpackage

// File: rtl/minimac2_crc32_nibble.sv
// -----------------------------------------------------------------------------
// minimac2_crc32_nibble
// Combinational one-nibble step of the reflected Ethernet CRC-32
// (polynomial 0xEDB88320). Feeding the nibbles of a byte low nibble first
// gives the same result as the usual byte-wise reflected CRC.
//
// Ports:
//   crc_in  [31:0]  current CRC register value
//   nib_in  [3:0]   nibble to absorb (bit 0 is the first bit on the wire)
//   crc_out [31:0]  CRC after absorbing nib_in
// -----------------------------------------------------------------------------
module minimac2_crc32_nibble
    import minimac2_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib_in,
    output logic [31:0] crc_out
);

    // Reflected CRC: xor the data into the low end, then shift right once per
    // data bit, folding the polynomial in whenever a 1 drops out of bit 0.
    always_comb begin
        crc_out = crc_in ^ {28'd0, nib_in};
        for (int i = 0; i < 4; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/minimac2_tx.sv
// -----------------------------------------------------------------------------
// minimac2_tx
// MII transmit framer. Reads payload bytes from the TX buffer RAM, sends
// preamble + SFD, the payload low nibble first, an optional CRC-32 FCS, then
// holds the line idle for the inter-frame gap before reporting completion.
//
// Parameters:
//   FCS_APPEND   1 = append the 4-byte FCS after the payload, 0 = payload only
//   IFG_NIBBLES  idle cycles between phy_tx_en falling and tx_done (>= 1)
//
// Ports:
//   phy_tx_clk         clock
//   phy_tx_rst         asynchronous active-high reset
//   tx_start           one-cycle frame request, honoured only when idle
//   tx_count    [10:0] payload byte count (1..2047), sampled with tx_start
//   tx_busy            high while a frame (including its IFG) is in progress
//   tx_done            one-cycle pulse at the end of the IFG
//   txb_adr     [10:0] TX buffer byte address
//   txb_dat     [7:0]  TX buffer read data (one cycle RAM latency)
//   phy_tx_en          MII TX enable
//   phy_tx_data [3:0]  MII TX nibble
// -----------------------------------------------------------------------------
module minimac2_tx
    import minimac2_pkg::*;
#(
    parameter int FCS_APPEND  = 1,
    parameter int IFG_NIBBLES = 24
) (
    input  logic        phy_tx_clk,
    input  logic        phy_tx_rst,
    input  logic        tx_start,
    input  logic [10:0] tx_count,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [10:0] txb_adr,
    input  logic [7:0]  txb_dat,
    output logic        phy_tx_en,
    output logic [3:0]  phy_tx_data
);

    // One counter serves the preamble, FCS and IFG phases.
    localparam int CNT_W = ($clog2(IFG_NIBBLES) > 4) ? $clog2(IFG_NIBBLES) : 4;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] SFD_AT   = CNT_W'(PREAMBLE_LEN - 2);
    localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_NIBBLES - 1);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_NIBBLES - 1);

    tx_state_e        state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [10:0]      count_q,       count_d;
    logic [10:0]      byte_idx_q,    byte_idx_d;
    logic             hi_next_q,     hi_next_d;
    logic [3:0]       hold_q,        hold_d;
    logic [31:0]      crc_q,         crc_d;
    logic [10:0]      txb_adr_q,     txb_adr_d;
    logic             tx_busy_q,     tx_busy_d;
    logic             tx_done_q,     tx_done_d;
    logic             phy_tx_en_q,   phy_tx_en_d;
    logic [3:0]       phy_tx_data_q, phy_tx_data_d;

    logic        load_low;
    logic        load_high;
    logic        fcs_emit;
    logic        ifg_enter;
    logic        last_byte;
    logic [3:0]  pay_nib;
    logic [31:0] crc_next;

    // The payload nibble that goes on the wire whenever a payload nibble is
    // loaded: the held high nibble after a low-nibble cycle, otherwise the
    // low nibble of the RAM word. Kept apart from the FSM logic so the CRC
    // step does not feed back into the block that consumes it.
    always_comb begin
        pay_nib = hi_next_q ? hold_q : txb_dat[3:0];
    end

    minimac2_crc32_nibble u_crc (
        .crc_in  (crc_q),
        .nib_in  (pay_nib),
        .crc_out (crc_next)
    );

    always_comb begin
        last_byte = (byte_idx_q == (count_q - 11'd1));
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        count_d       = count_q;
        byte_idx_d    = byte_idx_q;
        hi_next_d     = hi_next_q;
        hold_d        = hold_q;
        crc_d         = crc_q;
        txb_adr_d     = txb_adr_q;
        tx_busy_d     = tx_busy_q;
        tx_done_d     = 1'b0;
        phy_tx_en_d   = phy_tx_en_q;
        phy_tx_data_d = phy_tx_data_q;
        load_low      = 1'b0;
        load_high     = 1'b0;
        fcs_emit      = 1'b0;
        ifg_enter     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                txb_adr_d = '0;
                // A start coinciding with the tx_done pulse is dropped so the
                // control side sees a clean done before the next frame.
                if (tx_start && (tx_count != 11'd0) && !tx_done_q) begin
                    state_d       = ST_PREAMBLE;
                    count_d       = tx_count;
                    cnt_d         = '0;
                    byte_idx_d    = '0;
                    hi_next_d     = 1'b0;
                    crc_d         = CRC_INIT;
                    tx_busy_d     = 1'b1;
                    phy_tx_en_d   = 1'b1;
                    phy_tx_data_d = PREAMBLE_NIBBLE;
                end
            end

            ST_PREAMBLE: begin
                if (cnt_q == PRE_LAST) begin
                    // txb_adr has sat at 0 since IDLE, so byte 0 is ready.
                    state_d  = ST_DATA;
                    load_low = 1'b1;
                end else begin
                    cnt_d         = cnt_q + CNT_W'(1);
                    phy_tx_data_d = (cnt_q == SFD_AT) ? SFD_NIBBLE : PREAMBLE_NIBBLE;
                end
            end

            ST_DATA: begin
                if (hi_next_q) begin
                    load_high = 1'b1;
                end else if (last_byte) begin
                    cnt_d = '0;
                    if (FCS_APPEND != 0) begin
                        state_d  = ST_FCS;
                        fcs_emit = 1'b1;
                    end else begin
                        ifg_enter = 1'b1;
                    end
                end else begin
                    byte_idx_d = byte_idx_q + 11'd1;
                    load_low   = 1'b1;
                end
            end

            ST_FCS: begin
                if (cnt_q == FCS_LAST) begin
                    cnt_d     = '0;
                    ifg_enter = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    fcs_emit = 1'b1;
                end
            end

            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d   = ST_IDLE;
                    tx_done_d = 1'b1;
                    tx_busy_d = 1'b0;
                    txb_adr_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Low-nibble cycle: send the low nibble, park the high nibble and
        // move the address on. The address then stays put through the
        // high-nibble cycle, giving the RAM two edges before it is needed.
        if (load_low) begin
            phy_tx_data_d = pay_nib;
            hold_d        = txb_dat[7:4];
            txb_adr_d     = txb_adr_q + 11'd1;
            hi_next_d     = 1'b1;
            crc_d         = crc_next;
        end

        if (load_high) begin
            phy_tx_data_d = pay_nib;
            hi_next_d     = 1'b0;
            crc_d         = crc_next;
        end

        // FCS goes out as ~crc, least significant nibble first; the CRC
        // register itself is used as the shift register.
        if (fcs_emit) begin
            phy_tx_data_d = ~crc_q[3:0];
            crc_d         = {4'hF, crc_q[31:4]};
        end

        if (ifg_enter) begin
            state_d       = ST_IFG;
            phy_tx_en_d   = 1'b0;
            phy_tx_data_d = 4'h0;
        end
    end

    always_ff @(posedge phy_tx_clk or posedge phy_tx_rst) begin
        if (phy_tx_rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            count_q       <= '0;
            byte_idx_q    <= '0;
            hi_next_q     <= 1'b0;
            hold_q        <= '0;
            crc_q         <= CRC_INIT;
            txb_adr_q     <= '0;
            tx_busy_q     <= 1'b0;
            tx_done_q     <= 1'b0;
            phy_tx_en_q   <= 1'b0;
            phy_tx_data_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            count_q       <= count_d;
            byte_idx_q    <= byte_idx_d;
            hi_next_q     <= hi_next_d;
            hold_q        <= hold_d;
            crc_q         <= crc_d;
            txb_adr_q     <= txb_adr_d;
            tx_busy_q     <= tx_busy_d;
            tx_done_q     <= tx_done_d;
            phy_tx_en_q   <= phy_tx_en_d;
            phy_tx_data_q <= phy_tx_data_d;
        end
    end

    assign tx_busy     = tx_busy_q;
    assign tx_done     = tx_done_q;
    assign txb_adr     = txb_adr_q;
    assign phy_tx_en   = phy_tx_en_q;
    assign phy_tx_data = phy_tx_data_q;

endmodule
